// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one uart_tx between N byte requesters, round-robin with packet lock.
// Latency: grant is taken at the sampling edge; tx_start and req_ready rise one edge later.
// Backpressure: req_ready pulses once per captured byte; a requester holds its byte until then.
module uart_tx_arbiter #(
  parameter int N             = 3,
  parameter int START_TIMEOUT = 16,
  parameter int GW            = 3
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   req_valid,
  input  logic [N*8-1:0] req_data,
  input  logic [N-1:0]   req_last,
  output logic [N-1:0]   req_ready,
  output logic           tx_start,
  output logic [7:0]     tx_data,
  input  logic           tx_busy,
  output logic [GW-1:0]  grant_id,
  output logic           active,
  output logic           err_timeout
);

  localparam int            CW       = $clog2(START_TIMEOUT + 1);
  localparam logic [GW:0]   N_W      = (GW+1)'(N);
  localparam logic [CW-1:0] CNT_LAST = CW'(START_TIMEOUT - 1);

  typedef enum logic [2:0] {IDLE, SEND, WAIT_BUSY, WAIT_IDLE, HOLD} state_t;

  state_t        state_q, state_d;
  logic [GW-1:0] rr_ptr_q, rr_ptr_d;
  logic [GW-1:0] grant_q, grant_d;
  logic          locked_q, locked_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          tx_start_q, tx_start_d;
  logic [7:0]    tx_data_q, tx_data_d;
  logic [N-1:0]  ready_q, ready_d;
  logic          active_q, active_d;
  logic          err_q, err_d;

  logic          sel_valid;
  logic          sel_last;
  logic [7:0]    sel_data;
  logic          found;
  logic [GW-1:0] pick;
  logic [GW:0]   cand;

  // Mux out the request lines of the currently granted requester.
  always_comb begin
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_data  = '0;
    for (int i = 0; i < N; i++) begin
      if (grant_q == GW'(i)) begin
        sel_valid = req_valid[i];
        sel_last  = req_last[i];
        sel_data  = req_data[i*8 +: 8];
      end
    end
  end

  // Round-robin search: first valid requester after rr_ptr, wrapping at N.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    cand  = '0;
    for (int off = 1; off <= N; off++) begin
      cand = {1'b0, rr_ptr_q} + (GW+1)'(off);
      if (cand >= N_W) cand = cand - N_W;
      for (int i = 0; i < N; i++) begin
        if (!found && cand == (GW+1)'(i) && req_valid[i]) begin
          found = 1'b1;
          pick  = GW'(i);
        end
      end
    end
  end

  // Next-state and registered-output logic of the start/busy handshake.
  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    grant_d    = grant_q;
    locked_d   = locked_q;
    cnt_d      = cnt_q;
    tx_start_d = tx_start_q;
    tx_data_d  = tx_data_q;
    ready_d    = '0;
    err_d      = err_q;
    case (state_q)
      IDLE: begin
        // A frame left over from before reset must drain before any grant.
        if (!tx_busy && found) begin
          grant_d = pick;
          state_d = SEND;
        end
      end
      SEND: begin
        tx_data_d  = sel_data;
        tx_start_d = 1'b1;
        for (int i = 0; i < N; i++) begin
          if (grant_q == GW'(i)) ready_d[i] = 1'b1;
        end
        locked_d = ~sel_last;
        cnt_d    = '0;
        state_d  = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        cnt_d = cnt_q + CW'(1);
        if (tx_busy) begin
          tx_start_d = 1'b0;
          state_d    = WAIT_IDLE;
        end else if (cnt_q == CNT_LAST) begin
          // uart_tx never acknowledged: drop the byte and release the line.
          tx_start_d = 1'b0;
          err_d      = 1'b1;
          locked_d   = 1'b0;
          rr_ptr_d   = grant_q;
          state_d    = IDLE;
        end
      end
      WAIT_IDLE: begin
        if (!tx_busy) begin
          if (locked_q) begin
            state_d = HOLD;
          end else begin
            rr_ptr_d = grant_q;
            state_d  = IDLE;
          end
        end
      end
      HOLD: begin
        // Owner keeps the line until its last byte; everyone else waits.
        if (sel_valid) state_d = SEND;
      end
      default: state_d = IDLE;
    endcase
    active_d = (state_d != IDLE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      rr_ptr_q   <= GW'(N - 1);
      grant_q    <= '0;
      locked_q   <= 1'b0;
      cnt_q      <= '0;
      tx_start_q <= 1'b0;
      tx_data_q  <= '0;
      ready_q    <= '0;
      active_q   <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      grant_q    <= grant_d;
      locked_q   <= locked_d;
      cnt_q      <= cnt_d;
      tx_start_q <= tx_start_d;
      tx_data_q  <= tx_data_d;
      ready_q    <= ready_d;
      active_q   <= active_d;
      err_q      <= err_d;
    end
  end

  assign req_ready   = ready_q;
  assign tx_start    = tx_start_q;
  assign tx_data     = tx_data_q;
  assign grant_id    = grant_q;
  assign active      = active_q;
  assign err_timeout = err_q;

endmodule
